// File: rtl/apb_mc_ctrl_slave.sv
// APB4 register slave for the memory controller: per-rank MRW/MRR/PPR request
// handshakes, W1C done status, PPR pass/fail latch and a maskable interrupt.
module apb_mc_ctrl_slave #(
    parameter int APB_ADDRWIDTH = 16,
    parameter int APB_DATAWIDTH = 32,
    parameter int NB_RANK       = 4,
    parameter int WAIT_STATES   = 0
) (
    input  logic                       pclk_i,
    input  logic                       prst_ni,
    input  logic [APB_ADDRWIDTH-1:0]   paddr_i,
    input  logic                       psel_i,
    input  logic                       penable_i,
    input  logic                       pwrite_i,
    input  logic [APB_DATAWIDTH-1:0]   pwdata_i,
    input  logic [APB_DATAWIDTH/8-1:0] pstrb_i,
    output logic                       pready_o,
    output logic [APB_DATAWIDTH-1:0]   prdata_o,
    output logic                       pslverr_o,
    input  logic [NB_RANK-1:0]         mrw_done_status_i,
    input  logic [NB_RANK-1:0]         mrr_done_status_i,
    input  logic [NB_RANK-1:0]         ppr_done_status_i,
    input  logic [NB_RANK-1:0]         ppr_status_i,
    output logic [NB_RANK-1:0]         rank_mrw_o,
    output logic [NB_RANK-1:0]         rank_mrr_o,
    output logic [NB_RANK-1:0]         ppr_en_o,
    output logic                       mc_intr_o
);

    localparam int NB_BYTE = APB_DATAWIDTH / 8;
    localparam int LSB     = $clog2(NB_BYTE);
    localparam logic [APB_ADDRWIDTH-1:0] ALIGN_MASK = APB_ADDRWIDTH'((1 << LSB) - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_e;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       pready;

    always_ff @(posedge pclk_i or negedge prst_ni) begin
        if (!prst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (psel_i && !penable_i) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                if (psel_i) begin
                    state_d = ST_ACCESS;
                    cnt_d   = 3'(WAIT_STATES);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_q != 3'd0)               cnt_d   = cnt_q - 3'd1;
                else if (psel_i && !penable_i)   state_d = ST_SETUP;
                else                             state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pready = (state_q == ST_ACCESS) && (cnt_q == 3'd0);
    end

    logic [APB_ADDRWIDTH-1:0] idx;
    logic [2:0]               idx3;
    logic                     addr_err;
    logic                     wr_en;
    logic [7:0]               wr_sel;
    logic [APB_DATAWIDTH-1:0] wmask;
    logic [APB_DATAWIDTH-1:0] wr_bits;
    logic [NB_RANK-1:0]       wr_rank;
    logic                     unused_wr;

    assign idx       = paddr_i >> LSB;
    assign idx3      = idx[2:0];
    assign addr_err  = (|(paddr_i & ALIGN_MASK)) || (idx > APB_ADDRWIDTH'(7));
    assign wr_en     = pready && psel_i && pwrite_i && !addr_err;
    assign wr_sel    = wr_en ? (8'd1 << idx3) : 8'd0;
    assign wr_bits   = pwdata_i & wmask;
    assign wr_rank   = wr_bits[NB_RANK-1:0];
    assign unused_wr = ^wr_bits;

    always_comb begin
        wmask = '0;
        for (int b = 0; b < NB_BYTE; b++) wmask[b*8 +: 8] = {8{pstrb_i[b]}};
    end

    logic               ie_q, ie_d;
    logic               intr_q, intr_d;
    logic [NB_RANK-1:0] pend_mrw_q, pend_mrw_d, pend_mrr_q, pend_mrr_d, pend_ppr_q, pend_ppr_d;
    logic [NB_RANK-1:0] done_mrw_q, done_mrw_d, done_mrr_q, done_mrr_d, done_ppr_q, done_ppr_d;
    logic [NB_RANK-1:0] stat_q, stat_d;
    logic [NB_RANK-1:0] acc_mrw, acc_mrr, acc_ppr;
    logic               srst;

    // A done pulse only counts for a rank that actually has a request pending.
    assign acc_mrw = mrw_done_status_i & pend_mrw_q;
    assign acc_mrr = mrr_done_status_i & pend_mrr_q;
    assign acc_ppr = ppr_done_status_i & pend_ppr_q;
    assign srst    = wr_sel[0] && wr_bits[4];

    always_comb begin
        ie_d       = (wr_sel[0] && pstrb_i[0]) ? pwdata_i[0] : ie_q;
        pend_mrw_d = (pend_mrw_q & ~acc_mrw) | ({NB_RANK{wr_sel[1]}} & wr_rank & ~pend_mrw_q);
        pend_mrr_d = (pend_mrr_q & ~acc_mrr) | ({NB_RANK{wr_sel[2]}} & wr_rank & ~pend_mrr_q);
        pend_ppr_d = (pend_ppr_q & ~acc_ppr) | ({NB_RANK{wr_sel[3]}} & wr_rank & ~pend_ppr_q);
        done_mrw_d = (done_mrw_q & ~({NB_RANK{wr_sel[4]}} & wr_rank)) | acc_mrw;
        done_mrr_d = (done_mrr_q & ~({NB_RANK{wr_sel[5]}} & wr_rank)) | acc_mrr;
        done_ppr_d = (done_ppr_q & ~({NB_RANK{wr_sel[6]}} & wr_rank)) | acc_ppr;
        stat_d     = (stat_q & ~acc_ppr) | (ppr_status_i & acc_ppr);
        intr_d     = ie_q && (|(done_mrw_q | done_mrr_q | done_ppr_q));
        if (srst) begin
            ie_d       = 1'b0;
            intr_d     = 1'b0;
            pend_mrw_d = '0;
            pend_mrr_d = '0;
            pend_ppr_d = '0;
            done_mrw_d = '0;
            done_mrr_d = '0;
            done_ppr_d = '0;
            stat_d     = '0;
        end
    end

    always_ff @(posedge pclk_i or negedge prst_ni) begin
        if (!prst_ni) begin
            ie_q       <= 1'b0;
            intr_q     <= 1'b0;
            pend_mrw_q <= '0;
            pend_mrr_q <= '0;
            pend_ppr_q <= '0;
            done_mrw_q <= '0;
            done_mrr_q <= '0;
            done_ppr_q <= '0;
            stat_q     <= '0;
        end else begin
            ie_q       <= ie_d;
            intr_q     <= intr_d;
            pend_mrw_q <= pend_mrw_d;
            pend_mrr_q <= pend_mrr_d;
            pend_ppr_q <= pend_ppr_d;
            done_mrw_q <= done_mrw_d;
            done_mrr_q <= done_mrr_d;
            done_ppr_q <= done_ppr_d;
            stat_q     <= stat_d;
        end
    end

    logic [APB_DATAWIDTH-1:0] rdata;

    always_comb begin
        rdata = '0;
        case (idx3)
            3'd0: rdata[0]         = ie_q;
            3'd1: rdata[NB_RANK-1:0] = pend_mrw_q;
            3'd2: rdata[NB_RANK-1:0] = pend_mrr_q;
            3'd3: rdata[NB_RANK-1:0] = pend_ppr_q;
            3'd4: rdata[NB_RANK-1:0] = done_mrw_q;
            3'd5: rdata[NB_RANK-1:0] = done_mrr_q;
            3'd6: rdata[NB_RANK-1:0] = done_ppr_q;
            default: rdata[NB_RANK-1:0] = stat_q;
        endcase
    end

    assign pready_o   = pready;
    assign pslverr_o  = pready && addr_err;
    assign prdata_o   = (pready && !addr_err) ? rdata : '0;
    assign rank_mrw_o = pend_mrw_q;
    assign rank_mrr_o = pend_mrr_q;
    assign ppr_en_o   = pend_ppr_q;
    assign mc_intr_o  = intr_q;

endmodule
